// File: rtl/cpu32_pkg.sv
// +----------------------------------------------------------------------+
// | cpu32_pkg : shared port identifiers and limits for the cpu32 memory   |
// | subsystem.                                                            |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu32_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage : cpu32_pkg

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// +----------------------------------------------------------------------+
// | arb_starve_ctr : bounded count of consecutive data-port wins taken    |
// | while fetch is waiting.                                               |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_starve_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       at_limit
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule : arb_starve_ctr

`default_nettype wire

// File: rtl/sram_arbiter.sv
// +----------------------------------------------------------------------+
// | sram_arbiter : shares one single-port SRAM between fetch and data     |
// | ports; data has priority bounded by a starvation limit.               |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module sram_arbiter
    import cpu32_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic          sram_we,
    input  logic [DW-1:0] sram_rdata,
    output logic [15:0]   conflicts
);

    localparam logic [3:0] c_LIMIT = 4'(STARVE_MAX);

    logic        w_at_limit;
    logic        w_d_win;
    logic        w_i_win;
    logic        resp_v_q;
    logic        resp_v_d;
    port_e       resp_port_q;
    port_e       resp_port_d;
    logic [15:0] conflicts_q;
    logic [15:0] conflicts_d;

    // Data wins unless fetch is also pending and has waited its full share.
    always_comb begin
        w_d_win = d_req && (!i_req || !w_at_limit);
        w_i_win = i_req && !w_d_win;
        i_gnt   = w_i_win && !reset;
        d_gnt   = w_d_win && !reset;
    end

    assign sram_addr  = d_gnt ? d_addr : i_addr;
    assign sram_wdata = d_wdata;
    assign sram_we    = d_gnt && d_we;

    arb_starve_ctr u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (d_gnt && i_req),
        .clr      (i_gnt || !i_req),
        .limit    (c_LIMIT),
        .at_limit (w_at_limit)
    );

    always_comb begin
        resp_v_d    = i_gnt || (d_gnt && !d_we);
        resp_port_d = d_gnt ? PORT_D : PORT_I;
        conflicts_d = conflicts_q;
        if (i_req && d_req && (conflicts_q != CONFLICT_MAX)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_v_q    <= 1'b0;
            resp_port_q <= PORT_I;
            conflicts_q <= 16'd0;
        end else begin
            resp_v_q    <= resp_v_d;
            resp_port_q <= resp_port_d;
            conflicts_q <= conflicts_d;
        end
    end

    // Read data fans out unregistered; each rvalid qualifies its copy.
    assign i_rvalid  = resp_v_q && (resp_port_q == PORT_I);
    assign d_rvalid  = resp_v_q && (resp_port_q == PORT_D);
    assign i_rdata   = sram_rdata;
    assign d_rdata   = sram_rdata;
    assign conflicts = conflicts_q;

endmodule : sram_arbiter

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_sram_arbiter : randomized and directed bench for sram_arbiter      |
// | against a behavioural SRAM and arbitration model.                     |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sram_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we;
    logic [DW-1:0] sram_rdata;
    logic [15:0]   conflicts;

    sram_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .STARVE_MAX (STARVE_MAX)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata),
        .conflicts  (conflicts)
    );

    always #5 clk = ~clk;

    // SRAM macro stand-in: one-cycle read latency, 64 words.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr[5:0]] <= sram_wdata;
        sram_rdata <= mem[sram_addr[5:0]];
    end

    // Reference state
    logic [DW-1:0] ref_mem [64];
    int            m_starve = 0;
    int            m_conf   = 0;
    logic          p_v      = 1'b0;
    logic          p_is_d   = 1'b0;
    logic [DW-1:0] p_data   = '0;
    logic          last_i_gnt = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic rst, input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd);
        logic eg_i, eg_d;
        reset = rst; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
        eg_i = 1'b0; eg_d = 1'b0;
        if (!rst) begin
            if (dr && (!ir || m_starve < STARVE_MAX)) eg_d = 1'b1;
            else if (ir) eg_i = 1'b1;
        end
        last_i_gnt = i_gnt;
        check_eq("i_gnt", {63'd0, i_gnt}, {63'd0, eg_i});
        check_eq("d_gnt", {63'd0, d_gnt}, {63'd0, eg_d});
        check_eq("sram_we", {63'd0, sram_we}, {63'd0, eg_d && dw});
        check_eq("sram_addr", {32'd0, sram_addr}, {32'd0, eg_d ? da : ia});
        check_eq("sram_wdata", {32'd0, sram_wdata}, {32'd0, dwd});
        @(posedge clk);
        p_v    = eg_i || (eg_d && !dw);
        p_is_d = eg_d;
        p_data = ref_mem[(eg_d ? da[5:0] : ia[5:0])];
        if (eg_d && dw) ref_mem[da[5:0]] = dwd;
        if (rst) m_starve = 0;
        else if (eg_d && ir) m_starve = m_starve + 1;
        else m_starve = 0;
        if (rst) m_conf = 0;
        else if (ir && dr && m_conf < 65535) m_conf = m_conf + 1;
        #1;
        check_eq("i_rvalid", {63'd0, i_rvalid}, {63'd0, p_v && !p_is_d});
        check_eq("d_rvalid", {63'd0, d_rvalid}, {63'd0, p_v && p_is_d});
        if (p_v && !p_is_d) check_eq("i_rdata", {32'd0, i_rdata}, {32'd0, p_data});
        if (p_v && p_is_d)  check_eq("d_rdata", {32'd0, d_rdata}, {32'd0, p_data});
        check_eq("conflicts", {48'd0, conflicts}, 64'(m_conf));
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [7:0]  pat;
        logic        rr, ri, rd, rw;
        for (int k = 0; k < 64; k++) begin
            mem[k]     = $urandom;
            ref_mem[k] = mem[k];
        end
        mem[16]     = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        @(posedge clk); #1;
        idle(1'b1);
        idle(1'b1);
        check_eq("rst_conflicts", {48'd0, conflicts}, 64'd0);

        // Single fetch read
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        check_eq("fetch_rdata", {32'd0, i_rdata}, 64'hDEADBEEF);
        idle(1'b0);

        // Write then read back on data port
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        idle(1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h20, '0);
        check_eq("wr_rd_back", {32'd0, d_rdata}, 64'h12345678);

        // Contention: D,D,D,I,D,D,D,I
        idle(1'b1);
        pat = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 32'(k), 1'b1, 1'b0, 32'(k + 8), '0);
            pat[7-k] = last_i_gnt;
        end
        check_eq("contend_pattern", {56'd0, pat}, 64'h11);
        check_eq("contend_conf", {48'd0, conflicts}, 64'd8);
        idle(1'b0);

        // Alternating read responses
        step(1'b0, 1'b1, 32'h05, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h06, '0);
        idle(1'b0);

        // Reset mid-stream
        step(1'b0, 1'b1, 32'h07, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 32'h08, 1'b1, 1'b0, 32'h09, '0);
        step(1'b0, 1'b1, 32'h0A, 1'b1, 1'b0, 32'h0B, '0);
        check_eq("post_rst_dgnt_first", {63'd0, last_i_gnt}, 64'd0);
        idle(1'b0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rr = ($urandom_range(0, 63) == 0);
            ri = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1) == 1;
            step(rr, ri, 32'($urandom_range(0, 63)), rd, rw,
                 32'($urandom_range(0, 63)), $urandom);
        end

        // Conflict counter saturation
        idle(1'b1);
        for (int k = 0; k < 65540; k++) begin
            step(1'b0, 1'b1, 32'($urandom_range(0, 63)), 1'b1, 1'b0,
                 32'($urandom_range(0, 63)), '0);
        end
        check_eq("conf_saturate", {48'd0, conflicts}, 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sram_arbiter

`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares a single-port synchronous SRAM between the cpu32 instruction-fetch port and its data port. Each cycle, at most one port is granted. The data port has priority, bounded by a starvation limit that protects fetch. The arbiter tracks which port owns the one-cycle-latency read response and steers the valid strobe back to it. It sits between the core's i_addr/d_addr buses and the shared SRAM macro.

## Interface
- AW, default 32: address width.
- DW, default 32: data width.
- STARVE_MAX, default 3: maximum number of consecutive cycles the data port may win while i_req is pending. Legal range 1–15.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  fetch data valid on i_rdata.
- i_rdata  out  DW  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  data request is a write.
- d_addr  in  AW  data address.
- d_wdata  in  DW  data write data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  data read valid on d_rdata.
- d_rdata  out  DW  data read data.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  DW  SRAM write data.
- sram_we  out  1  SRAM write enable.
- sram_rdata  in  DW  SRAM read data; valid the cycle after the address is presented.
- conflicts  out  16  saturating count of cycles with i_req and d_req both high.

## Operation
**Grant decision** (combinational, from current requests and starve_cnt):
- Only d_req: d wins.
- Only i_req: i wins.
- Both, and starve_cnt < STARVE_MAX: d wins.
- Both, and starve_cnt == STARVE_MAX: i wins.
- Neither: no grant.
- Exactly one of i_gnt/d_gnt may be high. Both must be 0 while reset is high.

**SRAM drive:**
- sram_addr = d_addr when d is granted, otherwise i_addr (including idle).
- sram_wdata = d_wdata at all times.
- sram_we = d_gnt & d_we. It is never high without a grant.

**starve_cnt** (4-bit register, reset 0):
- Increments when d_gnt & i_req.
- Clears when i_gnt or !i_req.
- Never exceeds STARVE_MAX.

**Response tracking:**
- Registered resp_v and resp_port. Each is loaded every cycle with (grant & !write) and the granted port id.
- i_rvalid = resp_v & resp_port==PORT_I.
- d_rvalid = resp_v & resp_port==PORT_D.
- i_rdata = d_rdata = sram_rdata, unregistered fan-out. Data is meaningful only when the corresponding rvalid is high.

**conflicts:** increments when i_req & d_req, saturates at 16'hFFFF, and clears on reset.

**Requester rule:** a requester holds req, addr, we and wdata stable until it sees gnt. The arbiter does not latch requests.

## Timing
- Grant latency: 0 cycles. gnt is combinational in the same cycle as req.
- Read latency: a grant in cycle N produces rvalid and rdata in cycle N+1.
- Write: sram_we is asserted in the grant cycle N. No rvalid is produced.
- Back-to-back: one grant is allowed every cycle. Responses pipeline, so rvalid can be high on consecutive cycles and may alternate between ports.
- Reset values: i_gnt, d_gnt, sram_we = 0 while reset is high. i_rvalid, d_rvalid, conflicts, starve_cnt = 0 in the cycle after reset.
- Reset mid-operation: a read granted in the same cycle reset is asserted produces no rvalid. A read granted in the cycle before reset still returns its rvalid in the reset cycle. That response is harmless and requesters ignore it during reset.
- Starvation bound: with both requesting continuously, i is granted at least once every STARVE_MAX+1 cycles.
- A request deasserted without a grant is dropped. No state is retained for it.

## Structure
- Shared package cpu32_pkg contains:
  - PORT_I = 1'b0 and PORT_D = 1'b1.
  - Localparam CONFLICT_MAX = 16'hFFFF.
- One sub-module, arb_starve_ctr, holds the bounded counter. Its inputs are clk, reset, inc, clr and limit; its output is at_limit.
- Arbitration logic, response registers and the conflict counter stay in sram_arbiter.

## Test plan
- **Single-port reads:** i_req only, i_addr=0x10, SRAM holds 0xDEADBEEF at 0x10 → i_gnt the same cycle, sram_addr=0x10, i_rvalid=1 and i_rdata=0xDEADBEEF the next cycle, d_rvalid=0 throughout.
- **Write then read:**
  - d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 → sram_we=1 for exactly one cycle, no d_rvalid.
  - Then a d read of 0x20 → d_rvalid with 0x12345678 one cycle later.
- **Contention, STARVE_MAX=3:** i_req and d_req held high for 8 cycles → grant sequence D,D,D,I,D,D,D,I; conflicts=8.
- **Alternating responses:** grants I at N, D at N+1 (both reads) → i_rvalid only at N+1, d_rvalid only at N+2.
- **Reset mid-stream:**
  - Reset asserted during a granted read → no grants during reset, and no rvalid for the read granted in the reset cycle.
  - After reset: starve_cnt=0 and conflicts=0; first contention cycle grants D.
- **Saturation:** 65,540 cycles of dual requests → conflicts holds at 0xFFFF.
